biquad_cascade_sched: RTL and testbench
=======================================

# biquad_cascade_sched

Scheduler that time-multiplexes one external MAC16 accumulator slice across an NSTAGE-deep cascade of Q2.14 biquad sections for both stereo channels. It sits between the I2S receive path, which supplies `l_r_clk` and `sample_in`, and the output path. It owns all filter history, a shadowed coefficient bank and the MAC sequencing.

## Interface

Parameters:
- NSTAGE, 4: number of cascaded biquad sections (1..8).
- MAC_LAT, 2: cycles from a MAC clock-enable edge until `mac_result` reflects that product.

Ports:
- `clk`  in  1  high-speed system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `l_r_clk`  in  1  L/R select; each edge is a new sample. Channel is the synced level after the edge (0=left, 1=right).
- `sample_in`  in  16  signed x[n]; valid at the `l_r_clk` edge.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(NSTAGE)+3  {stage, idx}; idx 0..4 = b0, b1, b2, a1, a2; idx 5..7 ignored.
- `coef_wdata`  in  16  Q2.14 coefficient.
- `mac_a`, `mac_b`  out  16  MAC operands (coefficient, data).
- `mac_ce`  out  1  accumulate `mac_a`*`mac_b` this cycle.
- `mac_clr`  out  1  synchronous accumulator clear.
- `mac_result`  in  32  accumulator, Q4.28.
- `out_sample`  out  16  filtered y[n].
- `out_ch`  out  1  channel of `out_sample`.
- `out_valid`  out  1  one-cycle strobe.
- `busy`  out  1  FSM not IDLE.
- `overrun`  out  1  sticky sample-drop flag.

## Operation

- `l_r_clk` passes through a 2-flop synchronizer. An edge pulse is XOR of the synced and delayed values. On the pulse, {`sample_in`, channel} is captured.
- Capture buffer: a one-deep pending register. The edge loads it if it is empty. If it is full, the sample is dropped and `overrun` sets; `overrun` clears only on reset.
- Coefficients: writes go to the shadow bank any cycle. Shadow is copied to the active bank when the FSM leaves IDLE, so one sample always uses one consistent set.
- Reset coefficient values: b0=0x4000, all others 0 (unity passthrough).
- History: per channel, per stage: x1, x2, y1, y2, all reset to 0. The stage-k input is the stage-(k-1) output.
- FSM states: IDLE, LOAD, MAC, DRAIN, WB, DONE.
  - IDLE: leave for LOAD when pending is full. Pop pending; stage=0.
  - LOAD: `mac_clr`=1.
  - MAC: 5 cycles, tap 0..4, `mac_ce`=1. Operands per tap: (b0,x), (b1,x1), (b2,x2), (−a1,y1), (−a2,y2). Negation of 0x8000 yields 0x7FFF.
  - DRAIN: MAC_LAT cycles, `mac_ce`=0.
  - WB:
    - y = `mac_result`[29:14] + `mac_result`[13].
    - Saturate if `mac_result`[31:29] is not all-equal, or if the rounding add overflows: positive to 0x7FFF, negative to 0x8000.
    - Shift histories: x2←x1, x1←x, y2←y1, y1←y.
    - If stage<NSTAGE−1: stage++ and go to LOAD. Otherwise go to DONE.
  - DONE: `out_valid`=1, `out_sample`=y, `out_ch`=channel. Next state is IDLE.
- `mac_a`, `mac_b` are 0 whenever `mac_ce`=0.

## Timing

- All outputs reset to 0 asynchronously. Histories and pending are cleared; coefficients are restored to reset values; FSM goes to IDLE. A reset mid-sample abandons the sample with no `out_valid`.
- Cycle 0 is the IDLE cycle that sees pending full.
  - Per-stage cost: 7+MAC_LAT cycles.
  - DONE (`out_valid`) occurs at cycle 1+NSTAGE*(7+MAC_LAT). With defaults this is cycle 37.
- The edge pulse occurs 3 cycles after the raw `l_r_clk` transition.
- `busy` is high from LOAD through DONE inclusive.
- An edge in the same cycle as the pop is accepted into the freed slot, with no overrun.
- A coefficient write in the same cycle as the shadow→active copy lands in the shadow bank only. It applies from the next sample.
- `out_sample`/`out_ch` hold their values until the next DONE.

## Test plan

- Passthrough after reset: left edge with `sample_in`=0x1234 → `out_valid` at cycle 37 after the pulse, `out_sample`=0x1234, `out_ch`=0. The same check with a right edge and 0xEDCC → `out_ch`=1.
- Gain: write stage0 b0=0x2000 → sample 1000 yields 500; sample −1000 yields −500. A write issued mid-sample does not affect that sample's output.
- Feedback: stage0 a1=0xE000 (−0.5). Left impulse 0x4000, then zeros → 0x4000, 0x2000, 0x1000, 0x0800. Interleaved right zeros stay 0, proving channel-independent history.
- Saturation: stage0 b0=b1=0x7FFF, input 0x7FFF twice → second output 0x7FFF. Inputs of 0x8000 → 0x8000.
- Overrun: three edges within 10 cycles → the first two are processed back-to-back, the third is dropped, `overrun`=1, and exactly two `out_valid` pulses occur.
- Reset mid-operation: assert `reset` at cycle 15 → all outputs 0 immediately, no `out_valid`. The next sample 0x0100 → 0x0100 (coefficients back to passthrough).

Source files
------------

// File: rtl/biquad_cascade_sched_if.sv
// Bundles the sample, coefficient, MAC and result signals of biquad_cascade_sched.
// slave is the scheduler's view; master is the surrounding environment's view.
interface biquad_cascade_sched_if #(
    parameter int NSTAGE = 4
);
    localparam int AW = $clog2(NSTAGE) + 3;

    logic          l_r_clk;
    logic [15:0]   sample_in;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef_wdata;
    logic [15:0]   mac_a;
    logic [15:0]   mac_b;
    logic          mac_ce;
    logic          mac_clr;
    logic [31:0]   mac_result;
    logic [15:0]   out_sample;
    logic          out_ch;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    modport slave (
        input  l_r_clk, sample_in, coef_we, coef_addr, coef_wdata, mac_result,
        output mac_a, mac_b, mac_ce, mac_clr, out_sample, out_ch, out_valid, busy, overrun
    );

    modport master (
        output l_r_clk, sample_in, coef_we, coef_addr, coef_wdata, mac_result,
        input  mac_a, mac_b, mac_ce, mac_clr, out_sample, out_ch, out_valid, busy, overrun
    );
endinterface

// File: rtl/biquad_cascade_sched.sv
// Time-multiplexes one external MAC across NSTAGE stereo Q2.14 biquads; out_valid lands 1+NSTAGE*(7+MAC_LAT)
// cycles after the pending sample is seen. One-deep capture buffer: a sample arriving while it is full is dropped and sets overrun.
module biquad_cascade_sched #(
    parameter int NSTAGE  = 4,
    parameter int MAC_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    biquad_cascade_sched_if.slave bus
);
    localparam int AW = $clog2(NSTAGE) + 3;
    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_WB, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic            pend_vld_q, pend_vld_d, pend_ch_q, pend_ch_d;
    logic [15:0]     pend_dat_q, pend_dat_d;
    logic            overrun_q, overrun_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            ch_q, ch_d;
    logic [15:0]     xin_q, xin_d;
    logic [15:0]     out_sample_q, out_sample_d;
    logic            out_ch_q, out_ch_d;
    logic [15:0]     shadow_q [NSTAGE][5];
    logic [15:0]     shadow_d [NSTAGE][5];
    logic [15:0]     active_q [NSTAGE][5];
    logic [15:0]     active_d [NSTAGE][5];
    logic [15:0]     x1_q [2][NSTAGE], x1_d [2][NSTAGE];
    logic [15:0]     x2_q [2][NSTAGE], x2_d [2][NSTAGE];
    logic [15:0]     y1_q [2][NSTAGE], y1_d [2][NSTAGE];
    logic [15:0]     y2_q [2][NSTAGE], y2_d [2][NSTAGE];

    logic            edge_pulse, pop;
    logic [15:0]     tap_coef, tap_data, y_wb;
    logic [16:0]     rnd;
    logic            unused_mac_lsbs;

    function automatic logic [15:0] neg_sat(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
    endfunction

    assign edge_pulse      = sync2_q ^ sync3_q;
    assign unused_mac_lsbs = ^bus.mac_result[12:0];

    // Feedback taps carry negated a1/a2 so the accumulator only ever adds.
    always_comb begin
        tap_coef = '0;
        tap_data = '0;
        case (cnt_q[2:0])
            3'd0:    begin tap_coef = active_q[stage_q][0];          tap_data = xin_q;               end
            3'd1:    begin tap_coef = active_q[stage_q][1];          tap_data = x1_q[ch_q][stage_q]; end
            3'd2:    begin tap_coef = active_q[stage_q][2];          tap_data = x2_q[ch_q][stage_q]; end
            3'd3:    begin tap_coef = neg_sat(active_q[stage_q][3]); tap_data = y1_q[ch_q][stage_q]; end
            default: begin tap_coef = neg_sat(active_q[stage_q][4]); tap_data = y2_q[ch_q][stage_q]; end
        endcase
    end

    // Q4.28 -> Q2.14 with round-half-up; the rounding carry can only overflow toward +full-scale.
    always_comb begin
        rnd  = {bus.mac_result[29], bus.mac_result[29:14]} + {16'd0, bus.mac_result[13]};
        y_wb = rnd[15:0];
        if (bus.mac_result[31:29] != 3'b000 && bus.mac_result[31:29] != 3'b111)
            y_wb = bus.mac_result[31] ? 16'h8000 : 16'h7FFF;
        else if (rnd[16] != rnd[15])
            y_wb = rnd[16] ? 16'h8000 : 16'h7FFF;
    end

    always_comb begin
        state_d      = state_q;
        sync1_d      = bus.l_r_clk;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        pend_vld_d   = pend_vld_q;
        pend_ch_d    = pend_ch_q;
        pend_dat_d   = pend_dat_q;
        overrun_d    = overrun_q;
        stage_d      = stage_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        xin_d        = xin_q;
        out_sample_d = out_sample_q;
        out_ch_d     = out_ch_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: if (pend_vld_q) begin
                pop      = 1'b1;
                state_d  = S_LOAD;
                stage_d  = '0;
                ch_d     = pend_ch_q;
                xin_d    = pend_dat_q;
                active_d = shadow_q;
            end
            S_LOAD: begin
                state_d = S_MAC;
                cnt_d   = '0;
            end
            S_MAC: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd4) begin
                    cnt_d   = '0;
                    state_d = (MAC_LAT == 0) ? S_WB : S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(MAC_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                x2_d[ch_q][stage_q] = x1_q[ch_q][stage_q];
                x1_d[ch_q][stage_q] = xin_q;
                y2_d[ch_q][stage_q] = y1_q[ch_q][stage_q];
                y1_d[ch_q][stage_q] = y_wb;
                if (stage_q == SW'(NSTAGE - 1)) begin
                    state_d      = S_DONE;
                    out_sample_d = y_wb;
                    out_ch_d     = ch_q;
                end else begin
                    state_d = S_LOAD;
                    stage_d = stage_q + SW'(1);
                    xin_d   = y_wb;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The slot freed by a pop this cycle is immediately reusable.
        if (edge_pulse) begin
            if (!pend_vld_q || pop) begin
                pend_vld_d = 1'b1;
                pend_dat_d = bus.sample_in;
                pend_ch_d  = sync2_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pop) begin
            pend_vld_d = 1'b0;
        end

        for (int s = 0; s < NSTAGE; s++)
            for (int i = 0; i < 5; i++)
                if (bus.coef_we && bus.coef_addr == AW'(s * 8 + i))
                    shadow_d[s][i] = bus.coef_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_ch_q    <= 1'b0;
            pend_dat_q   <= '0;
            overrun_q    <= 1'b0;
            stage_q      <= '0;
            cnt_q        <= '0;
            ch_q         <= 1'b0;
            xin_q        <= '0;
            out_sample_q <= '0;
            out_ch_q     <= 1'b0;
            for (int s = 0; s < NSTAGE; s++) begin
                for (int i = 0; i < 5; i++) begin
                    shadow_q[s][i] <= (i == 0) ? 16'h4000 : 16'h0000;
                    active_q[s][i] <= (i == 0) ? 16'h4000 : 16'h0000;
                end
                for (int c = 0; c < 2; c++) begin
                    x1_q[c][s] <= '0;
                    x2_q[c][s] <= '0;
                    y1_q[c][s] <= '0;
                    y2_q[c][s] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            pend_vld_q   <= pend_vld_d;
            pend_ch_q    <= pend_ch_d;
            pend_dat_q   <= pend_dat_d;
            overrun_q    <= overrun_d;
            stage_q      <= stage_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            xin_q        <= xin_d;
            out_sample_q <= out_sample_d;
            out_ch_q     <= out_ch_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
        end
    end

    assign bus.mac_ce     = (state_q == S_MAC);
    assign bus.mac_clr    = (state_q == S_LOAD);
    assign bus.mac_a      = (state_q == S_MAC) ? tap_coef : 16'h0000;
    assign bus.mac_b      = (state_q == S_MAC) ? tap_data : 16'h0000;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.out_sample = out_sample_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Directed-vector bench for biquad_cascade_sched with a behavioural MAC16 and a queue-based output scoreboard.
module tb_biquad_cascade_sched;
    localparam int NSTAGE  = 4;
    localparam int MAC_LAT = 2;
    localparam int AW      = $clog2(NSTAGE) + 3;

    typedef struct {
        logic [15:0] dat;
        logic        ch;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    biquad_cascade_sched_if #(.NSTAGE(NSTAGE)) bus ();

    biquad_cascade_sched #(.NSTAGE(NSTAGE), .MAC_LAT(MAC_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External MAC: command registered once, accumulated on the following edge.
    logic        [15:0] pa, pb;
    logic               pce, pclr;
    logic signed [31:0] acc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pa <= '0; pb <= '0; pce <= 1'b0; pclr <= 1'b0; acc <= '0;
        end else begin
            pa   <= bus.mac_a;
            pb   <= bus.mac_b;
            pce  <= bus.mac_ce;
            pclr <= bus.mac_clr;
            if (pclr)
                acc <= '0;
            else if (pce)
                acc <= acc + $signed(pa) * $signed(pb);
        end
    end
    assign bus.mac_result = acc;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got sample 0x%0h ch %0d, expected no output",
                         bus.out_sample, bus.out_ch);
            end else begin
                e = expq.pop_front();
                check("out_sample", 32'(bus.out_sample), 32'(e.dat));
                check("out_ch", 32'(bus.out_ch), 32'(e.ch));
            end
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        bus.l_r_clk = 1'b0;
        bus.coef_we = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wcoef(input int stage, input int idx, input logic [15:0] v);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = AW'(stage * 8 + idx);
        bus.coef_wdata = v;
        @(posedge clk);
        #1 bus.coef_we = 1'b0;
    endtask

    // Toggles l_r_clk (new level = channel) and optionally queues the expected result.
    task automatic send(input logic [15:0] v, input logic [15:0] e, input bit push, input int gap);
        exp_t t;
        bus.l_r_clk   = ~bus.l_r_clk;
        bus.sample_in = v;
        if (push) begin
            t.dat = e;
            t.ch  = bus.l_r_clk;
            expq.push_back(t);
        end
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_out_sample"}, 32'(bus.out_sample), 32'd0);
        check({tag, "_out_ch"},     32'(bus.out_ch),     32'd0);
        check({tag, "_overrun"},    32'(bus.overrun),    32'd0);
        check({tag, "_mac_ce"},     32'(bus.mac_ce),     32'd0);
        check({tag, "_mac_clr"},    32'(bus.mac_clr),    32'd0);
        check({tag, "_mac_a"},      32'(bus.mac_a),      32'd0);
        check({tag, "_mac_b"},      32'(bus.mac_b),      32'd0);
    endtask

    initial begin
        int lat;
        bus.l_r_clk    = 1'b0;
        bus.sample_in  = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        do_reset();
        check_idle_outputs("reset");

        // Passthrough, with first-sample latency measured from the raw l_r_clk toggle.
        send(16'hEDCC, 16'hEDCC, 1, 0);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency_edges", 32'(lat), 32'd40);
        repeat (5) @(posedge clk);
        #1;
        check("hold_out_sample", 32'(bus.out_sample), 32'h0000EDCC);
        check("hold_out_ch", 32'(bus.out_ch), 32'd1);
        check("hold_out_valid", 32'(bus.out_valid), 32'd0);
        send(16'h1234, 16'h1234, 1, 10);
        check("busy_mid_sample", 32'(bus.busy), 32'd1);
        repeat (50) @(posedge clk);
        #1;

        // Gain 0.5; a write mid-sample only affects the following sample.
        do_reset();
        wcoef(0, 0, 16'h2000);
        send(16'd1000, 16'd500, 1, 60);
        send(16'hFC18, 16'hFE0C, 1, 10);
        wcoef(0, 0, 16'h1000);
        repeat (50) @(posedge clk);
        #1;
        send(16'd1000, 16'd250, 1, 60);

        // a1 = -0.5: left impulse decays by halves, right zeros stay zero.
        do_reset();
        wcoef(0, 3, 16'hE000);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h4000, 16'h4000, 1, 60);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h0000, 16'h2000, 1, 60);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h0000, 16'h1000, 1, 60);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h0000, 16'h0800, 1, 60);

        // Positive and negative saturation.
        do_reset();
        wcoef(0, 0, 16'h7FFF);
        wcoef(0, 1, 16'h7FFF);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h7FFF, 16'h7FFF, 1, 60);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h7FFF, 16'h7FFF, 1, 60);
        do_reset();
        wcoef(0, 0, 16'h7FFF);
        wcoef(0, 1, 16'h7FFF);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h8000, 16'h8000, 1, 60);
        send(16'h0000, 16'h0000, 1, 60);
        send(16'h8000, 16'h8000, 1, 60);

        // Three edges in 8 cycles: two processed, third dropped.
        do_reset();
        send(16'h0111, 16'h0111, 1, 4);
        send(16'h0222, 16'h0222, 1, 4);
        check("overrun_before_drop", 32'(bus.overrun), 32'd0);
        send(16'h0333, 16'h0000, 0, 4);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        repeat (100) @(posedge clk);
        #1;
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        check("out_sample_after_overrun", 32'(bus.out_sample), 32'h00000222);

        // Reset at cycle 15 of a sample processed with a non-default b0.
        wcoef(0, 0, 16'h2000);
        send(16'h0100, 16'h0000, 0, 18);
        check("busy_before_reset", 32'(bus.busy), 32'd1);
        reset       = 1'b1;
        bus.l_r_clk = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(16'h0100, 16'h0100, 1, 60);

        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
